// File: rtl/jts16b_io_master.sv
// jts16b_io_master
// Sequences 3-cycle bus accesses (ACC1, ACC2, GAP) to the cabinet I/O chip.
//   op 0: analogue serial read. One load write, then 8 single-bit reads,
//         MSB first, assembled into ana_val.
//   op 1: digital scan. Five reads into sys/p1/p2/dipa/dipb.
//   The digital scan can also be started by a falling edge of the
//   registered LVBL when auto_en is set.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, op, ch        request (sampled in IDLE only), op code, analogue channel
//   auto_en, LVBL        automatic scan enable, vertical blank (active-low)
//   cab_dout             registered read data from the cabinet
//   A, cpu_dout          address A[23:1], write data (always 0)
//   io_cs, LDSn, LDSWn   chip select, lower data/write strobes
//   UDSn, UDSWn          upper strobes, tied inactive
//   busy, done           operation in progress, completion pulse
//   *_val                result registers
//
// state | meaning
// IDLE  | waiting for start or auto trigger
// ACC1  | first access cycle, strobes asserted
// ACC2  | second access cycle, read data captured at its end
// GAP   | bus released; next access or finish
// FIN   | one-cycle done pulse
module jts16b_io_master (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [1:0]  ch,
    input  logic        auto_en,
    input  logic        LVBL,
    input  logic [7:0]  cab_dout,
    output logic [23:1] A,
    output logic [15:0] cpu_dout,
    output logic        io_cs,
    output logic        LDSn,
    output logic        LDSWn,
    output logic        UDSn,
    output logic        UDSWn,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ana_val,
    output logic [7:0]  sys_val,
    output logic [7:0]  p1_val,
    output logic [7:0]  p2_val,
    output logic [7:0]  dipa_val,
    output logic [7:0]  dipb_val
);

    typedef enum logic [2:0] {ST_IDLE, ST_ACC1, ST_ACC2, ST_GAP, ST_FIN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic        is_ana_q, is_ana_d;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  acc_q, acc_d;
    logic        lvbl_q, lvbl_d;
    logic        io_cs_q, io_cs_d;
    logic        lds_n_q, lds_n_d;
    logic        ldsw_n_q, ldsw_n_d;
    logic [23:1] a_q, a_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [7:0]  ana_val_q, ana_val_d;
    logic [7:0]  sys_q, sys_d;
    logic [7:0]  p1_q, p1_d;
    logic [7:0]  p2_q, p2_d;
    logic [7:0]  dipa_q, dipa_d;
    logic [7:0]  dipb_q, dipb_d;
    logic        auto_trig;
    logic        last_step;

    function automatic logic [23:1] addr_of(input logic is_ana, input logic [3:0] step,
                                            input logic [1:0] chn);
        logic [23:1] a;
        a = '0;
        if (is_ana) begin
            a[13:12] = 2'd3;
            a[5:4]   = 2'd2;
            a[2:1]   = chn;
        end else begin
            case (step)
                4'd0:    begin a[13:12] = 2'd1; a[2:1] = 2'd0; end
                4'd1:    begin a[13:12] = 2'd1; a[2:1] = 2'd1; end
                4'd2:    begin a[13:12] = 2'd1; a[2:1] = 2'd3; end
                4'd3:    begin a[13:12] = 2'd2; a[2:1] = 2'd1; end
                4'd4:    begin a[13:12] = 2'd2; a[2:1] = 2'd0; end
                default: a = '0;
            endcase
        end
        return a;
    endfunction

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        is_ana_d  = is_ana_q;
        ch_d      = ch_q;
        acc_d     = acc_q;
        lvbl_d    = LVBL;
        ana_val_d = ana_val_q;
        sys_d     = sys_q;
        p1_d      = p1_q;
        p2_d      = p2_q;
        dipa_d    = dipa_q;
        dipb_d    = dipb_q;
        // Falling edge of the registered LVBL, seen on the edge it happens.
        auto_trig = lvbl_q & ~LVBL & auto_en;
        last_step = is_ana_q ? (step_q == 4'd8) : (step_q == 4'd4);

        case (state_q)
            ST_IDLE: begin
                // start has priority; a simultaneous auto trigger is dropped.
                if (start && !op[1]) begin
                    state_d  = ST_ACC1;
                    step_d   = 4'd0;
                    is_ana_d = ~op[0];
                    ch_d     = ch;
                    acc_d    = 8'h00;
                end else if (auto_trig) begin
                    state_d  = ST_ACC1;
                    step_d   = 4'd0;
                    is_ana_d = 1'b0;
                    acc_d    = 8'h00;
                end
            end
            ST_ACC1: state_d = ST_ACC2;
            ST_ACC2: begin
                state_d = ST_GAP;
                if (is_ana_q) begin
                    if (step_q != 4'd0)
                        acc_d = {acc_q[6:0], cab_dout[0]};
                end else begin
                    case (step_q)
                        4'd0:    sys_d  = cab_dout;
                        4'd1:    p1_d   = cab_dout;
                        4'd2:    p2_d   = cab_dout;
                        4'd3:    dipa_d = cab_dout;
                        4'd4:    dipb_d = cab_dout;
                        default: ;
                    endcase
                end
            end
            ST_GAP: begin
                if (last_step) begin
                    state_d = ST_FIN;
                    if (is_ana_q)
                        ana_val_d = acc_q;
                end else begin
                    state_d = ST_ACC1;
                    step_d  = step_q + 4'd1;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Bus outputs are registered from the next state so they line up
        // with the state they belong to.
        io_cs_d  = (state_d == ST_ACC1) || (state_d == ST_ACC2);
        lds_n_d  = ~io_cs_d;
        ldsw_n_d = ~(io_cs_d & is_ana_d & (step_d == 4'd0));
        a_d      = io_cs_d ? addr_of(is_ana_d, step_d, ch_d) : '0;
        busy_d   = io_cs_d | (state_d == ST_GAP);
        done_d   = (state_d == ST_FIN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            step_q    <= 4'd0;
            is_ana_q  <= 1'b0;
            ch_q      <= 2'd0;
            acc_q     <= 8'h00;
            lvbl_q    <= 1'b1;
            io_cs_q   <= 1'b0;
            lds_n_q   <= 1'b1;
            ldsw_n_q  <= 1'b1;
            a_q       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ana_val_q <= 8'h00;
            sys_q     <= 8'hFF;
            p1_q      <= 8'hFF;
            p2_q      <= 8'hFF;
            dipa_q    <= 8'hFF;
            dipb_q    <= 8'hFF;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            is_ana_q  <= is_ana_d;
            ch_q      <= ch_d;
            acc_q     <= acc_d;
            lvbl_q    <= lvbl_d;
            io_cs_q   <= io_cs_d;
            lds_n_q   <= lds_n_d;
            ldsw_n_q  <= ldsw_n_d;
            a_q       <= a_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ana_val_q <= ana_val_d;
            sys_q     <= sys_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            dipa_q    <= dipa_d;
            dipb_q    <= dipb_d;
        end
    end

    assign A        = a_q;
    assign cpu_dout = 16'h0000;
    assign io_cs    = io_cs_q;
    assign LDSn     = lds_n_q;
    assign LDSWn    = ldsw_n_q;
    assign UDSn     = 1'b1;
    assign UDSWn    = 1'b1;
    assign busy     = busy_q;
    assign done     = done_q;
    assign ana_val  = ana_val_q;
    assign sys_val  = sys_q;
    assign p1_val   = p1_q;
    assign p2_val   = p2_q;
    assign dipa_val = dipa_q;
    assign dipb_val = dipb_q;

endmodule

// File: tb/tb_jts16b_io_master.sv
module tb_jts16b_io_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [1:0]  ch = 2'd0;
    logic        auto_en = 1'b0;
    logic        LVBL = 1'b1;
    logic [7:0]  cab_dout = 8'h00;
    logic [23:1] A;
    logic [15:0] cpu_dout;
    logic        io_cs, LDSn, LDSWn, UDSn, UDSWn, busy, done;
    logic [7:0]  ana_val, sys_val, p1_val, p2_val, dipa_val, dipb_val;

    jts16b_io_master dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ch(ch),
        .auto_en(auto_en), .LVBL(LVBL), .cab_dout(cab_dout),
        .A(A), .cpu_dout(cpu_dout), .io_cs(io_cs), .LDSn(LDSn), .LDSWn(LDSWn),
        .UDSn(UDSn), .UDSWn(UDSWn), .busy(busy), .done(done),
        .ana_val(ana_val), .sys_val(sys_val), .p1_val(p1_val), .p2_val(p2_val),
        .dipa_val(dipa_val), .dipb_val(dipb_val)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cabinet responder: registered read data, analogue shift register
    // loaded by the write and advanced in the gap after each analogue read.
    logic [7:0] ana_pre = 8'h00;
    logic [7:0] dig_val [5];
    logic [7:0] sr = 8'h00;
    bit         rd_ana = 1'b0;

    always @(posedge clk) begin
        if (io_cs && !LDSn) begin
            if (!LDSWn) begin
                if (A[13:12] == 2'd3) sr <= ana_pre;
            end else if (A[13:12] == 2'd3) begin
                cab_dout <= {7'd0, sr[7]};
                rd_ana   <= 1'b1;
            end else begin
                case ({A[13:12], A[2:1]})
                    4'b0100: cab_dout <= dig_val[0];
                    4'b0101: cab_dout <= dig_val[1];
                    4'b0111: cab_dout <= dig_val[2];
                    4'b1001: cab_dout <= dig_val[3];
                    4'b1000: cab_dout <= dig_val[4];
                    default: cab_dout <= 8'hEE;
                endcase
            end
        end else if (rd_ana) begin
            sr     <= {sr[6:0], 1'b0};
            rd_ana <= 1'b0;
        end
    end

    // Bus monitor
    logic [22:0] trace_a [$];
    bit          trace_w [$];
    int          trace_c [$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic        busy_at_done = 1'b0;
    logic        prev_cs = 1'b0;
    logic [22:0] last_a = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            check("strobes", {28'd0, LDSn, UDSn, UDSWn, io_cs | LDSWn},
                  {28'd0, ~io_cs, 1'b1, 1'b1, 1'b1});
            if (io_cs && !prev_cs) begin
                trace_a.push_back(A);
                trace_w.push_back(~LDSWn);
                trace_c.push_back(cyc);
            end else if (io_cs && prev_cs) begin
                check("a_stable", {9'd0, A}, {9'd0, last_a});
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc     = cyc;
                    busy_at_done = busy;
                end
            end
        end
        prev_cs = io_cs;
        last_a  = A;
    end

    // Reference model state
    logic [7:0] exp_ana = 8'h00;
    logic [7:0] exp_dig [5];
    int dig_hi [5] = '{1, 1, 1, 2, 2};
    int dig_lo [5] = '{0, 1, 3, 1, 0};

    task automatic check_results(input string tag);
        check({tag, "_ana"},  ana_val,  exp_ana);
        check({tag, "_sys"},  sys_val,  exp_dig[0]);
        check({tag, "_p1"},   p1_val,   exp_dig[1]);
        check({tag, "_p2"},   p2_val,   exp_dig[2]);
        check({tag, "_dipa"}, dipa_val, exp_dig[3]);
        check({tag, "_dipb"}, dipb_val, exp_dig[4]);
    endtask

    task automatic run_op(input string tag, input int opv, input int chv, input bit use_start,
                          input int restart_off, input bit lvbl_fall);
        int   n_edge;
        bit   runs;
        bit   ana;
        int   n_acc;
        int   ea;
        trace_a.delete(); trace_w.delete(); trace_c.delete();
        done_cnt = 0;
        done_cyc = -1;
        @(negedge clk);
        op    = opv[1:0];
        ch    = chv[1:0];
        start = use_start;
        if (lvbl_fall) LVBL = 1'b0;
        @(posedge clk);
        #1;
        n_edge = cyc;
        start  = 1'b0;
        runs   = use_start ? (opv < 2) : (lvbl_fall && auto_en);
        ana    = use_start && (opv == 0);
        check({tag, "_busy_n1"}, busy, runs);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (restart_off != 0 && (cyc - n_edge + 1) == restart_off) begin
                start = 1'b1;
                op    = 2'd1;
            end else begin
                start = 1'b0;
            end
        end
        n_acc = !runs ? 0 : (ana ? 9 : 5);
        check({tag, "_n_access"}, trace_a.size(), n_acc);
        check({tag, "_done_cnt"}, done_cnt, runs ? 1 : 0);
        if (runs) begin
            check({tag, "_done_cyc"}, done_cyc - n_edge + 1, ana ? 28 : 16);
            check({tag, "_busy_fin"}, busy_at_done, 0);
        end
        for (int i = 0; i < n_acc && i < trace_a.size(); i++) begin
            ea = ana ? ((3 << 11) | (2 << 3) | chv) : ((dig_hi[i] << 11) | dig_lo[i]);
            check($sformatf("%s_addr%0d", tag, i), {9'd0, trace_a[i]}, ea);
            check($sformatf("%s_wr%0d", tag, i), trace_w[i], (ana && i == 0) ? 1 : 0);
            check($sformatf("%s_slot%0d", tag, i), trace_c[i] - n_edge + 1, 1 + 3 * i);
        end
        if (runs) begin
            if (ana) exp_ana = ana_pre;
            else for (int i = 0; i < 5; i++) exp_dig[i] = dig_val[i];
        end
        check_results(tag);
        if (lvbl_fall) begin
            @(negedge clk);
            LVBL = 1'b1;
        end
    endtask

    initial begin
        int n_edge;
        for (int i = 0; i < 5; i++) begin
            exp_dig[i] = 8'hFF;
            dig_val[i] = 8'h00;
        end

        // Reset state
        #12;
        check("rst_io_cs", io_cs, 0);
        check("rst_A", {9'd0, A}, 0);
        check("rst_cpu_dout", cpu_dout, 0);
        check("rst_strobes", {LDSn, LDSWn, UDSn, UDSWn}, 4'hF);
        check("rst_busy_done", {busy, done}, 2'b00);
        check_results("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Analogue op, ch=2, responder preloaded with A5
        ana_pre = 8'hA5;
        run_op("ana_a5", 0, 2, 1, 0, 0);

        // Digital op with fixed values
        dig_val[0] = 8'h3C; dig_val[1] = 8'h11; dig_val[2] = 8'h22;
        dig_val[3] = 8'h0F; dig_val[4] = 8'hF0;
        run_op("dig_fix", 1, 0, 1, 0, 0);

        // Second start during an analogue op is dropped
        ana_pre = 8'($urandom);
        run_op("ana_restart", 0, 1, 1, 5, 0);

        // Start and auto trigger on the same edge: start wins
        auto_en = 1'b1;
        ana_pre = 8'($urandom);
        for (int i = 0; i < 5; i++) dig_val[i] = 8'($urandom);
        run_op("start_vs_auto", 0, 3, 1, 0, 1);
        auto_en = 1'b0;

        // Auto trigger alone runs a digital scan
        auto_en = 1'b1;
        for (int i = 0; i < 5; i++) dig_val[i] = 8'($urandom);
        run_op("auto_scan", 0, 0, 0, 0, 1);
        auto_en = 1'b0;

        // Ignored op codes
        run_op("op2", 2, 1, 1, 0, 0);
        run_op("op3", 3, 2, 1, 0, 0);

        // auto_en=0 with LVBL toggling: no bus activity
        trace_a.delete(); trace_w.delete(); trace_c.delete();
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (k % 3 == 0) LVBL = ~LVBL;
        end
        @(negedge clk);
        LVBL = 1'b1;
        repeat (3) @(negedge clk);
        check("lvbl_noauto_access", trace_a.size(), 0);
        check("lvbl_noauto_done", done_cnt, 0);

        // Random operations
        for (int r = 0; r < 4; r++) begin
            int opv;
            opv = int'($urandom_range(0, 1));
            ana_pre = 8'($urandom);
            for (int i = 0; i < 5; i++) dig_val[i] = 8'($urandom);
            run_op($sformatf("rand%0d", r), opv, int'($urandom_range(0, 3)), 1, 0, 0);
        end

        // Make sure ana_val is non-zero before the reset test
        ana_pre = 8'h5A;
        run_op("ana_pre_rst", 0, 0, 1, 0, 0);

        // Reset in the middle of an analogue op
        done_cnt = 0;
        ana_pre  = 8'hC3;
        @(negedge clk);
        start = 1'b1; op = 2'd0; ch = 2'd1;
        @(posedge clk);
        #1;
        n_edge = cyc;
        start  = 1'b0;
        repeat (9) @(negedge clk);
        @(posedge clk);
        #2;
        check("mid_busy_before", busy, 1);
        check("mid_cycle", cyc - n_edge + 1, 10);
        rst_n = 1'b0;
        #1;
        check("mid_rst_io_cs", io_cs, 0);
        check("mid_rst_strobes", {LDSn, LDSWn}, 2'b11);
        check("mid_rst_busy", busy, 0);
        exp_ana = 8'h00;
        for (int i = 0; i < 5; i++) exp_dig[i] = 8'hFF;
        check_results("mid_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("mid_rst_no_done", done_cnt, 0);
        check("mid_rst_idle_cs", io_cs, 0);
        check_results("mid_rst_after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
